dmac_xfer: RTL and testbench
============================

DMAC_XFER -- requirements
Module: dmac_xfer

Interface
REQ-001 SHALL have parameters: DW 32, data width; AW 32, address width; LENW 16, per-channel word-count width; BURST 4, max beats per grant.
REQ-002 SHALL have ports: clk input 1, sole clock, rising edge.
REQ-003 SHALL have rst input 1; reset is asynchronous and active-low.
REQ-004 SHALL have en_0..en_3 input 1 each, level grant from the DMA arbiter.
REQ-005 SHALL have req_done output 1, one-cycle end-of-grant pulse to the arbiter.
REQ-006 SHALL have target_0..target_3 output 1 each, direction per channel: 0 = read phase, 1 = write phase.
REQ-007 SHALL have ch_0_t0_done..ch_3_t0_done output 1 each, all source words read.
REQ-008 SHALL have cfg_we input 1, cfg_sel input 2, cfg_src input AW, cfg_dst input AW, cfg_len input LENW, channel load port.
REQ-009 SHALL have bus_req output 1, bus_wr output 1, bus_addr output AW, bus_wdata output DW, bus_rdata input DW, bus_ack input 1, single-beat master.
REQ-010 SHALL have fifo_sel output 2, fifo_push output 1, fifo_wdata output DW, fifo_pop output 1, fifo_rdata input DW (first-word-fall-through), fifo_empty input 4, fifo_full input 4.
REQ-011 SHALL have ch_done output 4, channel fully written, and err output 4, bus-timeout flags.

Function
REQ-012 cfg_we SHALL load channel cfg_sel: src_ptr=cfg_src, dst_ptr=cfg_dst, rd_cnt=wr_cnt=cfg_len, clearing t0_done, ch_done and err; cfg_we to the channel being serviced SHALL be ignored.
REQ-013 target_n SHALL be ch_n_t0_done OR fifo_full[n]; ch_n_t0_done SHALL be (rd_cnt==0); ch_done[n] SHALL be (wr_cnt==0).
REQ-014 FSM states SHALL be IDLE, RD, WR, DONE.
REQ-015 IDLE: on any en_n high, latch the lowest-index n as ch, latch target_n as dir, clear beat counter, go to RD (dir=0) or WR (dir=1).
REQ-016 RD: if rd_cnt==0, fifo_full[ch] or beats==BURST, go DONE; else drive bus_req=1, bus_wr=0, bus_addr=src_ptr, held stable until bus_ack.
REQ-017 On bus_ack in RD: fifo_push=1 that cycle with fifo_wdata=bus_rdata; src_ptr+=DW/8, rd_cnt-=1, beats+=1; stay in RD.
REQ-018 WR: if wr_cnt==0, fifo_empty[ch] or beats==BURST, go DONE; else drive bus_req=1, bus_wr=1, bus_addr=dst_ptr, bus_wdata=fifo_rdata until bus_ack.
REQ-019 On bus_ack in WR: fifo_pop=1 that cycle; dst_ptr+=DW/8, wr_cnt-=1, beats+=1; stay in WR.
REQ-020 DONE: req_done=1 for exactly one cycle, then IDLE; en SHALL be ignored in DONE.
REQ-021 fifo_sel SHALL equal the latched ch whenever not IDLE; fifo_full/fifo_empty SHALL be sampled as updated at the edge after a push/pop.
REQ-022 A grant with no eligible beat SHALL produce req_done 2 cycles after en rises (IDLE->RD/WR->DONE).
REQ-023 en_ch dropping mid-grant SHALL not abort an issued beat; the FSM SHALL finish it and go DONE.
REQ-024 Pointers SHALL wrap modulo 2^AW; counters SHALL never decrement below 0.

Reset
REQ-025 On rst low: state=IDLE; bus_req, bus_wr, fifo_push, fifo_pop, req_done=0; bus_addr, bus_wdata=0; fifo_sel=0; all pointers and counters=0, so t0_done=1, ch_done=1, target=1; err=0.
REQ-026 Reset mid-beat SHALL drop bus_req immediately without waiting for bus_ack.

Configuration
REQ-027 With DMAC_XFER_TIMEOUT_EN defined, an 8-bit counter SHALL run while bus_req=1 and clear on bus_ack; at 255 the beat aborts, err[ch]=1, rd_cnt/wr_cnt[ch] force to 0, FSM goes DONE.
REQ-028 Without DMAC_XFER_TIMEOUT_EN, bus_req SHALL wait indefinitely and err SHALL be constant 0.

Verification
REQ-029 Load ch0 src=0x1000 len=6, en_0 with target_0=0, ack every cycle -> 4 reads 0x1000..0x100C, 4 pushes, req_done; second grant -> 2 reads, ch_0_t0_done=1.
REQ-030 ch1 fifo holds 3 words, rd_cnt=0, en_1 -> 3 writes to dst 0x2000..0x2008 with popped data, fifo_empty stops the burst, req_done after 3rd ack.
REQ-031 ch2 len=8, fifo_full[2] rises after 2nd push -> exactly 2 reads, req_done, target_2=1.
REQ-032 en_0 and en_3 high together -> channel 0 serviced, fifo_sel=0.
REQ-033 rst low while bus_req=1 in WR -> bus_req=0 same cycle, all outputs at reset values.
REQ-034 With DMAC_XFER_TIMEOUT_EN, bus_ack held low -> abort after 255 cycles, err[ch]=1, req_done pulse, ch_done[ch]=1.

Source files
------------

// File: rtl/dmac_xfer.sv
// dmac_xfer: four-channel DMA transfer engine; moves words bus->fifo (RD) and
// fifo->bus (WR) in bursts of up to BURST single beats per arbiter grant.
// Ports: clk, rst (async active-low); en_0..en_3 grants, req_done end-of-grant;
// target_n / ch_n_t0_done channel status; cfg_* channel load; bus_* single-beat
// master; fifo_* per-channel FIFO (first-word-fall-through); ch_done, err flags.
// Optional macro DMAC_XFER_TIMEOUT_EN: 8-bit bus timeout that aborts a stuck beat.
module dmac_xfer #(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int LENW  = 16,
  parameter int BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_0,
  input  logic            en_1,
  input  logic            en_2,
  input  logic            en_3,
  output logic            req_done,
  output logic            target_0,
  output logic            target_1,
  output logic            target_2,
  output logic            target_3,
  output logic            ch_0_t0_done,
  output logic            ch_1_t0_done,
  output logic            ch_2_t0_done,
  output logic            ch_3_t0_done,
  input  logic            cfg_we,
  input  logic [1:0]      cfg_sel,
  input  logic [AW-1:0]   cfg_src,
  input  logic [AW-1:0]   cfg_dst,
  input  logic [LENW-1:0] cfg_len,
  output logic            bus_req,
  output logic            bus_wr,
  output logic [AW-1:0]   bus_addr,
  output logic [DW-1:0]   bus_wdata,
  input  logic [DW-1:0]   bus_rdata,
  input  logic            bus_ack,
  output logic [1:0]      fifo_sel,
  output logic            fifo_push,
  output logic [DW-1:0]   fifo_wdata,
  output logic            fifo_pop,
  input  logic [DW-1:0]   fifo_rdata,
  input  logic [3:0]      fifo_empty,
  input  logic [3:0]      fifo_full,
  output logic [3:0]      ch_done,
  output logic [3:0]      err
);

  localparam int BW = $clog2(BURST + 1);
  localparam logic [AW-1:0] STEP = AW'(DW / 8);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [1:0]      r_ch;
  logic [BW-1:0]   r_beats;
  logic            r_busy;
  logic [AW-1:0]   r_src [4];
  logic [AW-1:0]   r_dst [4];
  logic [LENW-1:0] r_rd  [4];
  logic [LENW-1:0] r_wr  [4];

  logic [3:0]      w_en;
  logic [3:0]      w_t0;
  logic [3:0]      w_tgt;
  logic [1:0]      w_pick;
  logic            w_burst;
  logic            w_rd_stop;
  logic            w_wr_stop;
  logic            w_rd_beat;
  logic            w_wr_beat;
  logic            w_abort;
  logic            w_tmo;
  logic            w_cfg_ok;

  assign w_en = {en_3, en_2, en_1, en_0};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_t0[i]    = (r_rd[i] == '0);
      ch_done[i] = (r_wr[i] == '0);
    end
  end

  assign w_tgt = w_t0 | fifo_full;

  assign ch_0_t0_done = w_t0[0];
  assign ch_1_t0_done = w_t0[1];
  assign ch_2_t0_done = w_t0[2];
  assign ch_3_t0_done = w_t0[3];
  assign target_0     = w_tgt[0];
  assign target_1     = w_tgt[1];
  assign target_2     = w_tgt[2];
  assign target_3     = w_tgt[3];

  // lowest-index grant wins
  always_comb begin
    w_pick = 2'd0;
    if (w_en[0])      w_pick = 2'd0;
    else if (w_en[1]) w_pick = 2'd1;
    else if (w_en[2]) w_pick = 2'd2;
    else if (w_en[3]) w_pick = 2'd3;
  end

  assign fifo_sel = (r_state == S_IDLE) ? 2'd0 : r_ch;
  assign w_burst  = (r_beats == BW'(BURST));

  // A beat already on the bus (r_busy) must complete before any stop,
  // including the grant being withdrawn.
  assign w_rd_stop = !r_busy &&
    ((r_rd[r_ch] == '0) || fifo_full[r_ch] || w_burst || !w_en[r_ch]);
  assign w_wr_stop = !r_busy &&
    ((r_wr[r_ch] == '0) || fifo_empty[r_ch] || w_burst || !w_en[r_ch]);

  assign w_cfg_ok = cfg_we && !((r_state != S_IDLE) && (cfg_sel == r_ch));

`ifdef DMAC_XFER_TIMEOUT_EN
  logic [7:0] r_tmo;
  logic [3:0] r_err;

  assign w_tmo = (r_tmo == 8'hFF);
  assign err   = r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo <= '0;
    end else if (!bus_req || bus_ack || w_abort) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= '0;
    end else begin
      if (w_abort) r_err[r_ch] <= 1'b1;
      if (w_cfg_ok) r_err[cfg_sel] <= 1'b0;
    end
  end
`else
  assign w_tmo = 1'b0;
  assign err   = '0;
`endif

  always_comb begin
    w_next     = r_state;
    bus_req    = 1'b0;
    bus_wr     = 1'b0;
    bus_addr   = '0;
    bus_wdata  = '0;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_wdata = '0;
    req_done   = 1'b0;
    w_rd_beat  = 1'b0;
    w_wr_beat  = 1'b0;
    w_abort    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (|w_en) w_next = w_tgt[w_pick] ? S_WR : S_RD;
      end
      S_RD: begin
        if (w_rd_stop) begin
          w_next = S_DONE;
        end else begin
          bus_req  = 1'b1;
          bus_addr = r_src[r_ch];
          if (bus_ack) begin
            fifo_push  = 1'b1;
            fifo_wdata = bus_rdata;
            w_rd_beat  = 1'b1;
          end else if (w_tmo) begin
            w_abort = 1'b1;
            w_next  = S_DONE;
          end
        end
      end
      S_WR: begin
        if (w_wr_stop) begin
          w_next = S_DONE;
        end else begin
          bus_req   = 1'b1;
          bus_wr    = 1'b1;
          bus_addr  = r_dst[r_ch];
          bus_wdata = fifo_rdata;
          if (bus_ack) begin
            fifo_pop  = 1'b1;
            w_wr_beat = 1'b1;
          end else if (w_tmo) begin
            w_abort = 1'b1;
            w_next  = S_DONE;
          end
        end
      end
      S_DONE: begin
        req_done = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ch    <= 2'd0;
      r_beats <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= bus_req && !bus_ack && !w_abort;
      if (r_state == S_IDLE) begin
        r_beats <= '0;
        if (|w_en) r_ch <= w_pick;
      end else if (w_rd_beat || w_wr_beat) begin
        r_beats <= r_beats + BW'(1);
      end
    end
  end

  // Beats only fire with a nonzero count, so counters never underflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        r_src[i] <= '0;
        r_dst[i] <= '0;
        r_rd[i]  <= '0;
        r_wr[i]  <= '0;
      end
    end else begin
      if (w_rd_beat) begin
        r_src[r_ch] <= r_src[r_ch] + STEP;
        r_rd[r_ch]  <= r_rd[r_ch] - LENW'(1);
      end
      if (w_wr_beat) begin
        r_dst[r_ch] <= r_dst[r_ch] + STEP;
        r_wr[r_ch]  <= r_wr[r_ch] - LENW'(1);
      end
      if (w_abort) begin
        r_rd[r_ch] <= '0;
        r_wr[r_ch] <= '0;
      end
      if (w_cfg_ok) begin
        r_src[cfg_sel] <= cfg_src;
        r_dst[cfg_sel] <= cfg_dst;
        r_rd[cfg_sel]  <= cfg_len;
        r_wr[cfg_sel]  <= cfg_len;
      end
    end
  end

endmodule

// File: tb/tb_dmac_xfer.sv
// tb_dmac_xfer: directed bench for dmac_xfer with a per-channel FIFO model
// and an always-ack bus slave whose read data is addr ^ 0xA5A50000.
module tb_dmac_xfer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  en = '0;
  logic        req_done;
  logic        target_0, target_1, target_2, target_3;
  logic        t0d_0, t0d_1, t0d_2, t0d_3;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_sel = '0;
  logic [31:0] cfg_src = '0;
  logic [31:0] cfg_dst = '0;
  logic [15:0] cfg_len = '0;
  logic        bus_req, bus_wr, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [1:0]  fifo_sel;
  logic        fifo_push, fifo_pop;
  logic [31:0] fifo_wdata, fifo_rdata;
  logic [3:0]  fifo_empty, fifo_full, ch_done, err;
  logic        ack_on = 1'b1;

  int errs = 0;
  int checks = 0;

  int          depth [4] = '{8, 3, 2, 8};
  int          fcnt  [4] = '{0, 0, 0, 0};
  logic [31:0] fm    [4][8];
  logic [31:0] la[$];
  logic [31:0] ld[$];
  logic        lw[$];

  always #5 clk = ~clk;

  assign bus_ack   = ack_on && bus_req;
  assign bus_rdata = bus_addr ^ 32'hA5A5_0000;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      fifo_full[i]  = (fcnt[i] >= depth[i]);
      fifo_empty[i] = (fcnt[i] == 0);
    end
  end
  assign fifo_rdata = fm[fifo_sel][0];

  always @(posedge clk) begin
    if (fifo_push) begin
      fm[fifo_sel][fcnt[fifo_sel]] <= fifo_wdata;
      fcnt[fifo_sel] <= fcnt[fifo_sel] + 1;
    end else if (fifo_pop) begin
      for (int j = 0; j < 7; j++) fm[fifo_sel][j] <= fm[fifo_sel][j+1];
      fcnt[fifo_sel] <= fcnt[fifo_sel] - 1;
    end
    if (rst && bus_req && bus_ack) begin
      la.push_back(bus_addr);
      lw.push_back(bus_wr);
      ld.push_back(bus_wr ? bus_wdata : bus_rdata);
    end
  end

  dmac_xfer dut (
    .clk(clk), .rst(rst),
    .en_0(en[0]), .en_1(en[1]), .en_2(en[2]), .en_3(en[3]),
    .req_done(req_done),
    .target_0(target_0), .target_1(target_1),
    .target_2(target_2), .target_3(target_3),
    .ch_0_t0_done(t0d_0), .ch_1_t0_done(t0d_1),
    .ch_2_t0_done(t0d_2), .ch_3_t0_done(t0d_3),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_src(cfg_src),
    .cfg_dst(cfg_dst), .cfg_len(cfg_len),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .fifo_sel(fifo_sel), .fifo_push(fifo_push), .fifo_wdata(fifo_wdata),
    .fifo_pop(fifo_pop), .fifo_rdata(fifo_rdata),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .ch_done(ch_done), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [31:0] src,
                     input logic [31:0] dst, input logic [15:0] len);
    @(negedge clk);
    cfg_we  = 1'b1;
    cfg_sel = ch;
    cfg_src = src;
    cfg_dst = dst;
    cfg_len = len;
    @(negedge clk);
    cfg_we  = 1'b0;
  endtask

  task automatic start(input logic [3:0] mask);
    @(negedge clk);
    la.delete();
    ld.delete();
    lw.delete();
    en = mask;
  endtask

  task automatic finish(input string tag, input int bound);
    int n;
    n = 0;
    while (!req_done && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rdone"}, {31'd0, req_done}, 32'd1);
    en = '0;
    @(negedge clk);
  endtask

  task automatic xfers(input string tag, input int n, input logic wr,
                       input logic [31:0] a0, input logic [31:0] d0);
    chk({tag, "_cnt"}, la.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < la.size()) begin
        chk({tag, "_addr"}, la[i], a0 + 32'(4 * i));
        chk({tag, "_wr"}, {31'd0, lw[i]}, {31'd0, wr});
        chk({tag, "_data"}, ld[i], d0 + 32'(4 * i));
      end else begin
        chk({tag, "_missing"}, 32'd0, 32'd1);
      end
    end
  endtask

  task automatic reset_state(input string tag);
    chk({tag, "_req"}, {31'd0, bus_req}, 32'd0);
    chk({tag, "_addr"}, bus_addr, 32'd0);
    chk({tag, "_wdata"}, bus_wdata, 32'd0);
    chk({tag, "_ctl"}, {28'd0, bus_wr, fifo_push, fifo_pop, req_done}, 32'd0);
    chk({tag, "_sel"}, {30'd0, fifo_sel}, 32'd0);
    chk({tag, "_chdone"}, {28'd0, ch_done}, 32'hF);
    chk({tag, "_tgt"}, {28'd0, target_3, target_2, target_1, target_0}, 32'hF);
    chk({tag, "_t0"}, {28'd0, t0d_3, t0d_2, t0d_1, t0d_0}, 32'hF);
    chk({tag, "_err"}, {28'd0, err}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset_state("rst");
    rst = 1'b1;
    @(negedge clk);

    // no eligible beat: req_done exactly 2 cycles after grant
    en = 4'b0100;
    @(posedge clk);
    #1 chk("lat_e1", {31'd0, req_done}, 32'd0);
    @(posedge clk);
    #1 chk("lat_e2", {31'd0, req_done}, 32'd1);
    @(negedge clk);
    en = '0;
    @(negedge clk);

    // ch0 read: 4-beat burst then remaining 2
    cfg(2'd0, 32'h1000, 32'h4000, 16'd6);
    chk("c0_tgt", {31'd0, target_0}, 32'd0);
    chk("c0_chd", {31'd0, ch_done[0]}, 32'd0);
    start(4'b0001);
    finish("c0a", 200);
    xfers("c0a", 4, 1'b0, 32'h1000, 32'hA5A5_1000);
    chk("c0a_t0", {31'd0, t0d_0}, 32'd0);
    start(4'b0001);
    finish("c0b", 200);
    xfers("c0b", 2, 1'b0, 32'h1010, 32'hA5A5_1010);
    chk("c0b_t0", {31'd0, t0d_0}, 32'd1);
    chk("c0b_fifo", fcnt[0], 32'd6);

    // ch1: fill a 3-deep fifo, then drain it to dst 0x2000
    cfg(2'd1, 32'h3000, 32'h2000, 16'd5);
    start(4'b0010);
    finish("c1r", 200);
    xfers("c1r", 3, 1'b0, 32'h3000, 32'hA5A5_3000);
    chk("c1r_tgt", {31'd0, target_1}, 32'd1);
    start(4'b0010);
    finish("c1w", 200);
    xfers("c1w", 3, 1'b1, 32'h2000, 32'hA5A5_3000);
    chk("c1w_chd", {31'd0, ch_done[1]}, 32'd0);
    chk("c1w_fifo", fcnt[1], 32'd0);

    // ch2: full after 2nd push ends the burst
    cfg(2'd2, 32'h5000, 32'h7000, 16'd8);
    start(4'b0100);
    finish("c2", 200);
    xfers("c2", 2, 1'b0, 32'h5000, 32'hA5A5_5000);
    chk("c2_tgt", {31'd0, target_2}, 32'd1);

    // en_0 and en_3 together: ch0 wins and writes back its data
    start(4'b1001);
    @(negedge clk);
    chk("pri_sel", {30'd0, fifo_sel}, 32'd0);
    chk("pri_addr", bus_addr, 32'h4000);
    chk("pri_wr", {31'd0, bus_wr}, 32'd1);
    finish("pri", 200);
    xfers("pri", 4, 1'b1, 32'h4000, 32'hA5A5_1000);
    chk("pri_fifo", fcnt[0], 32'd2);

    // reset while a write beat is pending
    ack_on = 1'b0;
    start(4'b0001);
    for (int n = 0; n < 20 && !bus_req; n++) @(negedge clk);
    chk("mid_req", {30'd0, bus_req, bus_wr}, 32'd3);
    #2 rst = 1'b0;
    #1 reset_state("mid");
    @(negedge clk);
    en = '0;
    ack_on = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

`ifdef DMAC_XFER_TIMEOUT_EN
    // bus never acks: beat aborts, err set, channel forced done
    cfg(2'd0, 32'h6000, 32'h0, 16'd2);
    ack_on = 1'b0;
    start(4'b0001);
    finish("tmo", 400);
    chk("tmo_err", {28'd0, err}, 32'h1);
    chk("tmo_chd", {31'd0, ch_done[0]}, 32'd1);
    chk("tmo_t0", {31'd0, t0d_0}, 32'd1);
    chk("tmo_cnt", la.size(), 32'd0);
    ack_on = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
